// File: rtl/gyro_pkg.sv
// Shared definitions for the gyro rate integrator: controller states and the
// Q16 rounding constants used by the scaling datapath.
package gyro_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INTEG,
        CAL,
        CAL_ACC,
        CAL_FIN
    } gyro_state_e;

    localparam int Q16_HALF  = 1 << 15;
    localparam int Q16_SHIFT = 16;

endpackage

// File: rtl/gyro_scale_sat.sv
// One-channel integration step: bias removal, Q16 gain with round-half-up,
// accumulate onto the angle, then saturate or wrap back to DW bits.
module gyro_scale_sat
    import gyro_pkg::*;
#(
    parameter int DW        = 16,
    parameter int K_SCALE   = 1311,
    parameter int WRAP_MODE = 0
) (
    input  logic signed [DW-1:0] sample_i,
    input  logic signed [DW-1:0] bias_i,
    input  logic signed [DW-1:0] angle_i,
    output logic signed [DW-1:0] angle_o
);

    localparam int PW = DW + 18;
    localparam logic signed [PW-1:0] HALF  = PW'(Q16_HALF);
    localparam logic signed [DW+1:0] S_MAX = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [DW+1:0] S_MIN = {3'b111, {(DW-1){1'b0}}};

    function automatic logic signed [DW+1:0] round_q16(input logic signed [PW-1:0] prod);
        return (DW+2)'((prod + HALF) >>> Q16_SHIFT);
    endfunction

    function automatic logic signed [DW-1:0] sat_dw(input logic signed [DW+1:0] sum);
        if (sum > S_MAX) begin
            return S_MAX[DW-1:0];
        end else if (sum < S_MIN) begin
            return S_MIN[DW-1:0];
        end
        return sum[DW-1:0];
    endfunction

    logic signed [DW:0]   d;
    logic signed [16:0]   k_s;
    logic signed [PW-1:0] p;
    logic signed [DW+1:0] delta;
    logic signed [DW+1:0] s;

    assign d     = {sample_i[DW-1], sample_i} - {bias_i[DW-1], bias_i};
    assign k_s   = {1'b0, 16'(K_SCALE)};
    assign p     = PW'(d) * PW'(k_s);
    assign delta = round_q16(p);
    assign s     = {{2{angle_i[DW-1]}}, angle_i} + delta;

    assign angle_o = (WRAP_MODE == 1) ? s[DW-1:0] : sat_dw(s);

endmodule

// File: rtl/gyro_integrator.sv
// Multi-channel gyro integrator: one channel per cycle through a shared
// scaling datapath, with an averaging bias calibration mode.
module gyro_integrator
    import gyro_pkg::*;
#(
    parameter int N_CH      = 3,
    parameter int DW        = 16,
    parameter int K_SCALE   = 1311,
    parameter int CAL_LOG2  = 8,
    parameter int WRAP_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_CH*DW-1:0]   in_data,
    input  logic                 cal_start,
    input  logic                 clr,
    output logic [N_CH*DW-1:0]   angle,
    output logic [N_CH*DW-1:0]   bias,
    output logic                 out_valid,
    output logic                 cal_busy,
    output logic                 cal_done
);

    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int AW = DW + CAL_LOG2;
    localparam int NW = CAL_LOG2 + 1;

    gyro_state_e          state_q, state_d;
    logic [CW-1:0]        ch_q, ch_d;
    logic [NW-1:0]        cnt_q, cnt_d;
    logic                 out_valid_q, cal_done_q;

    logic signed [DW-1:0] data_q  [N_CH];
    logic signed [DW-1:0] angle_q [N_CH];
    logic signed [DW-1:0] bias_q  [N_CH];
    logic signed [AW-1:0] acc_q   [N_CH];

    logic                 transfer, last_ch;
    logic                 capture, integ_we, acc_clr, acc_we, fin;
    logic signed [DW-1:0] angle_nxt;

    assign in_ready = (state_q == IDLE) || (state_q == CAL);
    assign transfer = in_valid && in_ready;
    assign last_ch  = (ch_q == CW'(N_CH - 1));
    assign cal_busy = (state_q == CAL) || (state_q == CAL_ACC) || (state_q == CAL_FIN);
    assign out_valid = out_valid_q;
    assign cal_done  = cal_done_q;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        capture  = 1'b0;
        integ_we = 1'b0;
        acc_clr  = 1'b0;
        acc_we   = 1'b0;
        fin      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cal_start) begin
                    state_d = CAL;
                    acc_clr = 1'b1;
                    cnt_d   = '0;
                end else if (transfer) begin
                    capture = 1'b1;
                    ch_d    = '0;
                    state_d = INTEG;
                end
            end
            INTEG: begin
                integ_we = 1'b1;
                if (last_ch) begin
                    ch_d    = '0;
                    state_d = IDLE;
                end else begin
                    ch_d = ch_q + CW'(1);
                end
            end
            CAL: begin
                if (transfer) begin
                    capture = 1'b1;
                    ch_d    = '0;
                    state_d = CAL_ACC;
                end
            end
            CAL_ACC: begin
                acc_we = 1'b1;
                if (last_ch) begin
                    ch_d    = '0;
                    cnt_d   = cnt_q + NW'(1);
                    // the sample being folded in now is the last one of the window
                    state_d = (cnt_q == NW'((1 << CAL_LOG2) - 1)) ? CAL_FIN : CAL;
                end else begin
                    ch_d = ch_q + CW'(1);
                end
            end
            CAL_FIN: begin
                fin     = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            cal_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            out_valid_q <= integ_we && last_ch;
            cal_done_q  <= fin;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < N_CH; i++) begin
                data_q[i] <= in_data[i*DW +: DW];
            end
        end
    end

    gyro_scale_sat #(
        .DW        (DW),
        .K_SCALE   (K_SCALE),
        .WRAP_MODE (WRAP_MODE)
    ) u_scale (
        .sample_i (data_q[ch_q]),
        .bias_i   (bias_q[ch_q]),
        .angle_i  (angle_q[ch_q]),
        .angle_o  (angle_nxt)
    );

    // clr and calibration completion both override the per-channel update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                angle_q[i] <= '0;
                bias_q[i]  <= '0;
                acc_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (clr || fin) begin
                    angle_q[i] <= '0;
                end else if (integ_we && (ch_q == CW'(i))) begin
                    angle_q[i] <= angle_nxt;
                end
                if (fin) begin
                    bias_q[i] <= DW'(acc_q[i] >>> CAL_LOG2);
                end
                if (acc_clr) begin
                    acc_q[i] <= '0;
                end else if (acc_we && (ch_q == CW'(i))) begin
                    acc_q[i] <= acc_q[i] + {{CAL_LOG2{data_q[i][DW-1]}}, data_q[i]};
                end
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_pack
        assign angle[g*DW +: DW] = angle_q[g];
        assign bias[g*DW +: DW]  = bias_q[g];
    end

endmodule

// File: tb/tb_gyro_integrator.sv
// Bench for gyro_integrator: a saturating and a wrapping instance share the
// stimulus; a transaction-level model predicts every output each cycle.
module tb_gyro_integrator;

    localparam int NCH = 3;
    localparam int KS  = 1311;
    localparam int L2  = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, cal_start, clr;
    logic [47:0] in_data;

    logic [47:0] angle_s, bias_s, angle_w, bias_w;
    logic ready_s, ov_s, busy_s, done_s;
    logic ready_w, ov_w, busy_w, done_w;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gyro_integrator #(.N_CH(NCH), .DW(16), .K_SCALE(KS), .CAL_LOG2(L2), .WRAP_MODE(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready_s), .in_data(in_data),
        .cal_start(cal_start), .clr(clr), .angle(angle_s), .bias(bias_s),
        .out_valid(ov_s), .cal_busy(busy_s), .cal_done(done_s)
    );

    gyro_integrator #(.N_CH(NCH), .DW(16), .K_SCALE(KS), .CAL_LOG2(L2), .WRAP_MODE(1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready_w), .in_data(in_data),
        .cal_start(cal_start), .clr(clr), .angle(angle_w), .bias(bias_w),
        .out_valid(ov_w), .cal_busy(busy_w), .cal_done(done_w)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int     e = 0;
    int     free_edge = 0;
    int     ov_edge = -1;
    int     fin_edge = -1;
    int     upd_edge [NCH] = '{-1, -1, -1};
    longint m_in  [NCH] = '{0, 0, 0};
    longint m_sat [NCH] = '{0, 0, 0};
    longint m_wrp [NCH] = '{0, 0, 0};
    longint m_bias[NCH] = '{0, 0, 0};
    longint m_acc [NCH] = '{0, 0, 0};
    bit     m_cal = 1'b0;
    int     m_cnt = 0;

    function automatic longint step(longint a, longint x, longint b, bit wrap);
        longint p, s;
        logic [15:0] w;
        p = (x - b) * KS + 32768;
        s = a + (p >>> 16);
        if (wrap) begin
            w = s[15:0];
            return longint'($signed(w));
        end
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_edge = 0; ov_edge = -1; fin_edge = -1; m_cal = 0; m_cnt = 0;
            for (int i = 0; i < NCH; i++) begin
                upd_edge[i] = -1; m_sat[i] = 0; m_wrp[i] = 0; m_bias[i] = 0; m_acc[i] = 0;
            end
        end else begin
            e++;
            for (int i = 0; i < NCH; i++) begin
                if (e == upd_edge[i]) begin
                    m_sat[i] = step(m_sat[i], m_in[i], m_bias[i], 1'b0);
                    m_wrp[i] = step(m_wrp[i], m_in[i], m_bias[i], 1'b1);
                end
                if (clr) begin
                    m_sat[i] = 0; m_wrp[i] = 0;
                end
            end
            if (e == fin_edge) begin
                m_cal = 0;
                for (int i = 0; i < NCH; i++) begin
                    m_bias[i] = m_acc[i] >>> L2; m_sat[i] = 0; m_wrp[i] = 0;
                end
            end
            if (e >= free_edge) begin
                if (!m_cal && cal_start) begin
                    m_cal = 1; m_cnt = 0; free_edge = e + 1;
                    for (int i = 0; i < NCH; i++) m_acc[i] = 0;
                end else if (in_valid) begin
                    if (m_cal) begin
                        for (int i = 0; i < NCH; i++) m_acc[i] += longint'($signed(in_data[i*16 +: 16]));
                        m_cnt++;
                        if (m_cnt == (1 << L2)) begin
                            fin_edge = e + NCH + 1; free_edge = e + NCH + 2;
                        end else begin
                            free_edge = e + NCH + 1;
                        end
                    end else begin
                        for (int i = 0; i < NCH; i++) begin
                            m_in[i] = longint'($signed(in_data[i*16 +: 16]));
                            upd_edge[i] = e + 1 + i;
                        end
                        ov_edge = e + NCH; free_edge = e + NCH + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready_sat", ready_s, (e + 1 >= free_edge));
        chk("in_ready_wrap", ready_w, (e + 1 >= free_edge));
        chk("out_valid_sat", ov_s, (e == ov_edge));
        chk("out_valid_wrap", ov_w, (e == ov_edge));
        chk("cal_done", done_s, (e == fin_edge));
        chk("cal_busy", busy_s, m_cal);
        chk("cal_busy_wrap", busy_w, m_cal);
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("angle_sat[%0d]", i), longint'($signed(angle_s[i*16 +: 16])), m_sat[i]);
            chk($sformatf("angle_wrap[%0d]", i), longint'($signed(angle_w[i*16 +: 16])), m_wrp[i]);
            chk($sformatf("bias[%0d]", i), longint'($signed(bias_s[i*16 +: 16])), m_bias[i]);
            chk($sformatf("bias_wrap[%0d]", i), longint'($signed(bias_w[i*16 +: 16])), m_bias[i]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic send(input int x0, input int x1, input int x2, input bit clr_ch0);
        bit r;
        int n;
        @(posedge clk); #2;
        in_valid = 1'b1;
        in_data  = {16'(x2), 16'(x1), 16'(x0)};
        n = 0;
        do begin
            @(negedge clk); r = ready_s;
            @(posedge clk); n++;
        end while (!r && n < 40);
        if (!r) chk("send_timeout", 0, 1);
        #2 in_valid = 1'b0;
        if (clr_ch0) begin
            clr = 1'b1;
            @(posedge clk); #2 clr = 1'b0;
        end
    endtask

    task automatic wait_ov(output int n);
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!ov_s && n < 20);
        if (!ov_s) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #2 clr = 1'b1;
        @(posedge clk); #2 clr = 1'b0;
    endtask

    task automatic start_cal();
        @(posedge clk); #2 cal_start = 1'b1;
        @(posedge clk); #2 cal_start = 1'b0;
        @(negedge clk);
        chk("lit_cal_busy_on_entry", busy_s, 1);
    endtask

    function automatic longint ch(input logic [47:0] v, input int i);
        return longint'($signed(v[i*16 +: 16]));
    endfunction

    initial begin
        int lat;
        int n;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; cal_start = 1'b0; clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("lit_rst_angle", longint'(angle_s), 0);
        chk("lit_rst_bias", longint'(bias_s), 0);
        chk("lit_rst_out_valid", ov_s, 0);
        chk("lit_rst_cal_busy", busy_s, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        chk("lit_ready_after_reset", ready_s, 1);

        send(1000, 0, 0, 1'b0);
        wait_ov(lat);
        chk("lit_latency", lat, 4);
        chk("lit_angle0_pos", ch(angle_s, 0), 20);

        send(-1000, 0, 0, 1'b0);
        wait_ov(lat);
        chk("lit_angle0_back_to_zero", ch(angle_s, 0), 0);

        send(0, 5000, -3000, 1'b0);
        wait_ov(lat);
        chk("lit_angle1", ch(angle_s, 1), 100);
        chk("lit_angle2", ch(angle_s, 2), -60);

        for (int k = 0; k < 50; k++) begin
            send(32767, 0, 0, 1'b0);
            wait_ov(lat);
        end
        send(500, 0, 0, 1'b0);
        wait_ov(lat);
        chk("lit_angle0_32760", ch(angle_s, 0), 32760);
        chk("lit_angle0_32760_wrap", ch(angle_w, 0), 32760);
        send(32767, 0, 0, 1'b0);
        wait_ov(lat);
        chk("lit_angle0_saturated", ch(angle_s, 0), 32767);
        chk("lit_angle0_wrapped", ch(angle_w, 0), -32121);

        pulse_clr();
        @(negedge clk);
        chk("lit_clr_all", longint'(angle_s), 0);

        send(1000, 1000, 0, 1'b1);
        wait_ov(lat);
        chk("lit_clr_beats_ch0", ch(angle_s, 0), 0);
        chk("lit_ch1_after_clr", ch(angle_s, 1), 20);

        pulse_clr();
        @(posedge clk); #2;
        in_valid = 1'b1;
        in_data  = {16'd0, 16'd0, 16'd1000};
        repeat (5) @(posedge clk);
        #2 in_valid = 1'b0;
        wait_ov(lat);
        chk("lit_held_valid_two_transfers", ch(angle_s, 0), 40);

        start_cal();
        send(100, -7, 0, 1'b0);
        send(102, -8, 0, 1'b0);
        send(98, -7, 0, 1'b0);
        send(104, -8, 0, 1'b0);
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!done_s && n < 20);
        chk("lit_cal_done_seen", done_s, 1);
        chk("lit_bias0", ch(bias_s, 0), 101);
        chk("lit_bias1", ch(bias_s, 1), -8);
        chk("lit_cal_clears_angle", longint'(angle_s), 0);

        send(101, -8, 0, 1'b0);
        wait_ov(lat);
        chk("lit_bias_cancels", longint'(angle_s), 0);
        send(1101, 0, 0, 1'b0);
        wait_ov(lat);
        chk("lit_bias_applied", ch(angle_s, 0), 20);

        start_cal();
        send(50, 0, 0, 1'b0);
        send(60, 0, 0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("lit_rst_mid_cal_bias", longint'(bias_s), 0);
        chk("lit_rst_mid_cal_busy", busy_s, 0);
        chk("lit_rst_mid_cal_ready", ready_s, 1);
        @(posedge clk); #2 rst_n = 1'b1;

        send(1000, 0, 0, 1'b0);
        wait_ov(lat);
        chk("lit_after_mid_cal_reset", ch(angle_s, 0), 20);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
